uart_transmitter: RTL and testbench

- UART serial transmitter; the counterpart of the team's UART receiver.
- Accepts parallel bytes over a valid/ready handshake.
- Serialises each byte as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- Each bit is held for CLKS_PER_BIT clocks. Default CLKS_PER_BIT=1 gives one bit per clock, which matches the existing receiver so the two loop back directly.

---
 rtl/uart_transmitter_pkg.sv | 15 +
 rtl/uart_baud_tick.sv | 33 +++
 rtl/uart_transmitter.sv | 124 ++++++++++++
 tb/tb_uart_transmitter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: frame FSM states and line-level constants.
package uartUtil;

  typedef enum logic [1:0] {
    IDLE,
    START,
    SEND,
    STOP
  } states_t;

  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;
  localparam int unsigned DATA_BITS = 8;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer. Counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// every bit period.
//   clk    : clock
//   rst    : synchronous reset, active-high
//   clear  : restart the bit period (timer back to 0)
//   bitEnd : high in the final cycle of the current bit period
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bitEnd
);

  // For CLKS_PER_BIT=1 the timer is a single bit stuck at 0, so every
  // cycle is a final bit cycle.
  localparam int unsigned W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] bitTimer;

  assign bitEnd = (bitTimer == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear || bitEnd) begin
      bitTimer <= '0;
    end else begin
      bitTimer <= bitTimer + W'(1);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART serial transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit,
// each bit held for CLKS_PER_BIT clocks. Bytes arrive over valid/ready.
//   clk     : clock
//   rst     : synchronous reset, active-high (aborts any frame)
//   txData  : byte to send, sampled on acceptance
//   txValid : txData is valid
//   txReady : a byte can be accepted this cycle
//   txOut   : registered serial line, idles high
//   busy    : frame in progress
//   done    : pulse in the final cycle of the stop bit
module uart_transmitter
  import uartUtil::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] txData,
  input  logic       txValid,
  output logic       txReady,
  output logic       txOut,
  output logic       busy,
  output logic       done
);

  if (DATA_BITS != uartUtil::DATA_BITS) begin : g_bad_data_bits
    $error("uart_transmitter: DATA_BITS must be 8");
  end
  if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
    $error("uart_transmitter: CLKS_PER_BIT must be 1..65535");
  end

  states_t    state, stateNext;
  logic [7:0] shift, shiftNext;
  logic [2:0] bitIndex, bitIndexNext;
  logic       txOutNext;
  logic       accept;
  logic       bitEnd;
  logic       timerClear;

  // Timer is held at 0 while idle so a new frame always starts a full bit.
  assign timerClear = (state == IDLE) || accept;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (timerClear),
    .bitEnd(bitEnd)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      shift    <= '0;
      bitIndex <= '0;
      txOut    <= STOP_BIT;
    end else begin
      state    <= stateNext;
      shift    <= shiftNext;
      bitIndex <= bitIndexNext;
      txOut    <= txOutNext;
    end
  end

  always_comb begin
    stateNext    = state;
    shiftNext    = shift;
    bitIndexNext = bitIndex;
    txOutNext    = STOP_BIT;
    txReady      = (state == IDLE) || ((state == STOP) && bitEnd);
    done         = (state == STOP) && bitEnd;
    busy         = (state != IDLE);
    accept       = txValid && txReady;

    case (state)
      IDLE: begin
        if (accept) begin
          stateNext = START;
          shiftNext = txData;
        end
      end
      START: begin
        if (bitEnd) begin
          stateNext    = SEND;
          bitIndexNext = '0;
        end
      end
      SEND: begin
        if (bitEnd) begin
          shiftNext = shift >> 1;
          if (bitIndex == 3'd7) begin
            stateNext    = STOP;
            bitIndexNext = '0;
          end else begin
            bitIndexNext = bitIndex + 3'd1;
          end
        end
      end
      STOP: begin
        if (bitEnd) begin
          if (accept) begin
            stateNext = START;
            shiftNext = txData;
          end else begin
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase

    // The line value is computed from the upcoming state so that txOut is a
    // plain register yet lines up with the state it belongs to.
    case (stateNext)
      START:   txOutNext = START_BIT;
      SEND:    txOutNext = shiftNext[0];
      default: txOutNext = STOP_BIT;
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
module tb_uart_transmitter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] txData;
  logic       txValid, txReady, txOut, busy, done;
  logic [7:0] txData4;
  logic       txValid4, txReady4, txOut4, busy4, done4;

  uart_transmitter #(.CLKS_PER_BIT(1), .DATA_BITS(8)) dut1 (
    .clk(clk), .rst(rst), .txData(txData), .txValid(txValid),
    .txReady(txReady), .txOut(txOut), .busy(busy), .done(done)
  );

  uart_transmitter #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut4 (
    .clk(clk), .rst(rst), .txData(txData4), .txValid(txValid4),
    .txReady(txReady4), .txOut(txOut4), .busy(busy4), .done(done4)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] txq[$];
  logic       expBits[$];
  logic [7:0] rxq[$];

  // Sends every byte of txq on dut1 (CLKS_PER_BIT=1) with txValid held, so
  // frames run back-to-back. The line is checked against the ideal bit
  // stream and also decoded by a simple receiver model.
  task automatic run_stream(input string tag);
    int n;
    int idx;
    int c;
    int budget;
    int rxCnt;
    int doneCnt;
    bit started;
    bit will;
    logic [7:0] rxSh;
    n = txq.size();
    idx = 0; c = 0; rxCnt = -1; doneCnt = 0; started = 0; rxSh = '0;
    expBits.delete();
    rxq.delete();
    foreach (txq[k]) begin
      expBits.push_back(1'b0);
      for (int b = 0; b < 8; b++) expBits.push_back(txq[k][b]);
      expBits.push_back(1'b1);
    end
    budget = 10 * n + 20;
    txData  = txq[0];
    txValid = 1'b1;
    while (c < 10 * n && budget > 0) begin
      budget--;
      will = txValid && txReady;
      @(negedge clk);
      if (will && !started) started = 1;
      if (started) begin
        c++;
        check({tag, ".txOut"},   txOut,   expBits[c-1]);
        check({tag, ".done"},    done,    (c % 10 == 0));
        check({tag, ".txReady"}, txReady, (c % 10 == 0));
        check({tag, ".busy"},    busy,    1'b1);
        if (done) doneCnt++;
        if (rxCnt < 0) begin
          if (txOut === 1'b0) rxCnt = 0;
        end else if (rxCnt < 8) begin
          rxSh[rxCnt] = txOut;
          rxCnt++;
        end else begin
          if (txOut === 1'b1) rxq.push_back(rxSh);
          rxCnt = -1;
        end
      end
      if (will) begin
        idx++;
        if (idx < n) txData = txq[idx];
        else txValid = 1'b0;
      end
    end
    txValid = 1'b0;
    check({tag, ".cycles"},    c,          10 * n);
    check({tag, ".doneCount"}, doneCnt,    n);
    check({tag, ".rxCount"},   rxq.size(), n);
    for (int i = 0; i < n && i < rxq.size(); i++)
      check({tag, ".rxByte"}, rxq[i], txq[i]);
    @(negedge clk);
    check({tag, ".idleOut"},   txOut,   1'b1);
    check({tag, ".idleBusy"},  busy,    1'b0);
    check({tag, ".idleReady"}, txReady, 1'b1);
  endtask

  // One frame on dut4 (CLKS_PER_BIT=4): 40 cycles, each frame bit held 4.
  task automatic run4(input logic [7:0] b, input string tag);
    int fb;
    logic e;
    txData4  = b;
    txValid4 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        txValid4 = 1'b0;
        txData4  = ~b;
      end
      fb = (c - 1) / 4;
      if (fb == 0) e = 1'b0;
      else if (fb == 9) e = 1'b1;
      else e = b[fb-1];
      check({tag, ".txOut"}, txOut4, e);
      check({tag, ".done"},  done4,  (c == 40));
    end
    @(negedge clk);
    check({tag, ".idleBusy"}, busy4,  1'b0);
    check({tag, ".idleOut"},  txOut4, 1'b1);
  endtask

  initial begin
    int doneSeen;
    logic line[10];
    logic [7:0] decoded;

    rst = 1'b1;
    txData = '0; txValid = 1'b0;
    txData4 = '0; txValid4 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.txOut",   txOut,   1'b1);
    check("reset.txReady", txReady, 1'b1);
    check("reset.busy",    busy,    1'b0);
    check("reset.done",    done,    1'b0);
    check("reset4.txOut",  txOut4,  1'b1);
    check("reset4.busy",   busy4,   1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Single frame.
    txq = '{8'hA5};
    run_stream("a5");

    // Held valid, two back-to-back frames.
    txq = '{8'h00, 8'hFF};
    run_stream("b2b");

    // Slow bit rate.
    run4(8'h01, "cpb4_01");
    run4(8'($urandom), "cpb4_rnd");

    // Reset in the middle of a frame.
    doneSeen = 0;
    txData  = 8'h3C;
    txValid = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 1) begin
        txValid = 1'b0;
        check("abort.startBit", txOut, 1'b0);
      end
      if (done) doneSeen++;
      if (c == 5) rst = 1'b1;
    end
    @(negedge clk);
    check("abort.txOut",   txOut,   1'b1);
    check("abort.busy",    busy,    1'b0);
    check("abort.txReady", txReady, 1'b1);
    check("abort.done",    done,    1'b0);
    check("abort.noDone",  doneSeen, 0);
    rst = 1'b0;
    txq = '{8'h81};
    run_stream("after_abort");

    // Input changes and a stray valid pulse while busy are ignored.
    txData  = 8'h55;
    txValid = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      line[c-1] = txOut;
      if (c == 1) txValid = 1'b0;
      if (c == 2) txData  = 8'hAA;
      if (c == 3) txValid = 1'b1;
      if (c == 4) txValid = 1'b0;
    end
    for (int b = 0; b < 8; b++) decoded[b] = line[b+1];
    check("hold.start", line[0], 1'b0);
    check("hold.data",  decoded, 8'h55);
    check("hold.stop",  line[9], 1'b1);
    @(negedge clk);
    check("hold.noSecondFrame", busy, 1'b0);

    // Random loopback, 256 bytes back-to-back.
    txq.delete();
    for (int i = 0; i < 256; i++) txq.push_back(8'($urandom));
    run_stream("loop");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
